cp0_int_ctrl: RTL and testbench
===============================

Name: cp0_int_ctrl

Overview:
Coprocessor-0 interrupt/exception responder for the P7 CPU. It consumes the IRQ lines driven by memory-mapped devices such as the timer, applies the status mask, and raises a one-cycle-decided exception request to the pipeline. On a taken request it latches EPC/Cause/EXL. It sits beside the M stage, is accessed by mfc0/mtc0, and is released by eret.

Parameters:
- PRID, 32'h1234_5678, value returned by the read-only PRId register (reg 15).
- HWINT_W, 6, number of hardware interrupt lines, mapped to Cause/SR bits [15:10].

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- A1  in  5  mfc0 read register index.
- A2  in  5  mtc0 write register index.
- Din  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction currently in M.
- BD  in  1  instruction in M is in a branch delay slot.
- ExcCode  in  5  pending internal exception code from the pipeline; 0 means none.
- HWInt  in  HWINT_W  device IRQ lines; bit 0 is the timer IRQ.
- EXLClr  in  1  eret in M.
- Req  out  1  exception/interrupt taken this cycle (combinational).
- EPC  out  32  current EPC register, used as the eret target.
- Dout  out  32  mfc0 read data (combinational).

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14).
  - PRId (15) = PRID.
  - Any other index reads 32'h0.
- Reset (reset low, asynchronous): SR=0, Cause=0, EPC=0. Req is therefore 0 and Dout follows A1 from the reset values.
- IP sampling: Cause.IP <= HWInt on every clock edge, unconditionally, including during writes and while Req is asserted. Reading Cause returns the IP value from the previous edge.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL. Raw HWInt is used, so there is zero-cycle latency from the IRQ line to Req.
- ExcReq = (ExcCode != 0) & ~SR.EXL.
- Req = IntReq | ExcReq. Interrupt has priority over an internal exception.
- On an edge with Req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCode.
  - Cause.BD <= BD.
  - EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
  - Any mtc0 write in the same cycle is discarded; EXLClr in the same cycle is ignored.
- On an edge with Req=0 and WE=1:
  - A2=12 writes SR.IM, EXL and IE from Din; other bits are dropped.
  - A2=14 writes EPC <= {Din[31:2],2'b00}.
  - Cause and PRId are read-only; writes to them and to unmapped indices are ignored.
- On an edge with Req=0 and EXLClr=1: SR.EXL <= 0. If WE targeting SR coincides, EXLClr wins for the EXL bit and the other SR fields take Din.
- Re-entrancy: while EXL=1, no new Req is raised even if HWInt stays high. Once EXL clears, a still-asserted masked IRQ raises Req in that same cycle. The device must deassert its IRQ (handler writes the timer ctrl) to avoid a loop.
- Arithmetic: EPC subtract is 32-bit modulo; PC=0 with BD=1 wraps to 32'hFFFF_FFFC.

Decomposition:
- Package cp0_pkg holds:
  - register indices: SR=12, CAUSE=13, EPC=14, PRID=15;
  - field bit positions: IM 15:10, IP 15:10, EXL 1, IE 0, BD 31, ExcCode 6:2;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- One natural combinational sub-module: cp0_req_arb. It computes IntReq/ExcReq/Req and the selected ExcCode from HWInt, SR and ExcCode.
- Register file and update priority stay in the top.

Test Plan:
1. Reset low mid-operation with EXL=1 and EPC=0x3004 -> immediately SR=0, EPC=0, Req=0, Dout(A1=14)=0.
2. mtc0 SR=0x0000_0401 (IM0=1, IE=1), then HWInt=6'b000001 with PC=0x3010, BD=0 -> Req=1 that cycle; next edge EPC=0x3010, Cause.ExcCode=0, EXL=1, Req=0 though HWInt stays 1.
3. ExcCode=12 (Ov) with PC=0x3020, BD=1, no IRQ -> Req=1; EPC=0x301C, Cause.BD=1, Cause.ExcCode=12.
4. Simultaneous masked IRQ and ExcCode=10 -> ExcCode latched as 0 (interrupt wins); a mtc0 EPC=0x5000 in the same cycle is discarded.
5. EXL=1 with HWInt held high, EXLClr pulse -> EXL clears and Req rises in the following cycle. Then clear the IRQ, eret again -> Req stays 0.
6. mtc0 Cause=0xFFFF_FFFF and read A1=15 -> Cause unchanged except IP tracks HWInt; Dout=PRID. Read A1=3 -> 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt/exception responder: register
// indices, field positions, exception codes and the EPC target helper.
package cp0_pkg;

  localparam int unsigned NUM_HWINT = 6;

  // mfc0/mtc0 register indices
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Field positions within SR and Cause
  localparam int unsigned IM_LSB  = 10;
  localparam int unsigned IP_LSB  = 10;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned EXC_LSB = 2;
  localparam int unsigned EXC_W   = 5;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Word-aligned PC of the faulting instruction, or of its branch when the
  // instruction sits in a delay slot. Wraps modulo 2^32.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    logic [31:0] pc_al;
    pc_al = {pc[31:2], 2'b00};
    return bd ? (pc_al - 32'd4) : pc_al;
  endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline <-> CP0 signal bundle. The pipeline drives as master; the CP0
// block responds as slave.
interface cp0_int_ctrl_if #(
  parameter int unsigned HWINT_W = cp0_pkg::NUM_HWINT
);
  logic [4:0]         A1;
  logic [4:0]         A2;
  logic [31:0]        Din;
  logic               WE;
  logic [31:0]        PC;
  logic               BD;
  logic [4:0]         ExcCode;
  logic [HWINT_W-1:0] HWInt;
  logic               EXLClr;
  logic               Req;
  logic [31:0]        EPC;
  logic [31:0]        Dout;

  modport master (
    output A1, A2, Din, WE, PC, BD, ExcCode, HWInt, EXLClr,
    input  Req, EPC, Dout
  );

  modport slave (
    input  A1, A2, Din, WE, PC, BD, ExcCode, HWInt, EXLClr,
    output Req, EPC, Dout
  );
endinterface

// File: rtl/cp0_req_arb.sv
// Combinational request arbiter: decides whether an interrupt or internal
// exception is taken this cycle and which ExcCode gets latched.
module cp0_req_arb
  import cp0_pkg::*;
#(
  parameter int unsigned HWINT_W = NUM_HWINT
) (
  input  logic [HWINT_W-1:0] hwint,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  input  logic [4:0]         exc_code,
  output logic               int_req,
  output logic               exc_req,
  output logic               req,
  output logic [4:0]         sel_code
);

  // Raw IRQ lines feed straight through for zero-cycle interrupt latency;
  // interrupts take priority over a pending internal exception.
  always_comb begin
    int_req  = (|(hwint & im)) & ie & ~exl;
    exc_req  = (exc_code != EXC_INT) & ~exl;
    req      = int_req | exc_req;
    sel_code = int_req ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception responder: SR/Cause/EPC/PRId register file,
// update priority (taken request > mtc0 / eret) and mfc0 read mux.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h1234_5678,
  parameter int unsigned HWINT_W = NUM_HWINT
) (
  input logic          clk,
  input logic          reset,
  cp0_int_ctrl_if.slave bus
);

  // SR fields
  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  // Cause fields
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [4:0]         exc_q, exc_d;
  // EPC
  logic [31:0]        epc_q, epc_d;

  logic               int_req;
  logic               exc_req;
  logic               req;
  logic [4:0]         sel_code;
  logic [31:0]        sr_rd;
  logic [31:0]        cause_rd;
  logic [31:0]        dout;

  cp0_req_arb #(
    .HWINT_W (HWINT_W)
  ) u_req_arb (
    .hwint    (bus.HWInt),
    .im       (im_q),
    .ie       (ie_q),
    .exl      (exl_q),
    .exc_code (bus.ExcCode),
    .int_req  (int_req),
    .exc_req  (exc_req),
    .req      (req),
    .sel_code (sel_code)
  );

  // Next-state: a taken request overrides mtc0 and eret; eret beats mtc0 on EXL.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = bus.HWInt;  // IP tracks the lines every edge, unconditionally

    if (req) begin
      exl_d = 1'b1;
      exc_d = sel_code;
      bd_d  = bus.BD;
      epc_d = epc_target(bus.PC, bus.BD);
    end else begin
      if (bus.WE && (bus.A2 == REG_SR)) begin
        im_d  = bus.Din[IM_LSB +: HWINT_W];
        exl_d = bus.Din[EXL_BIT];
        ie_d  = bus.Din[IE_BIT];
      end
      if (bus.WE && (bus.A2 == REG_EPC)) begin
        epc_d = {bus.Din[31:2], 2'b00};
      end
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux; unimplemented bits and unmapped indices read as zero.
  always_comb begin
    sr_rd                        = '0;
    sr_rd[IM_LSB +: HWINT_W]     = im_q;
    sr_rd[EXL_BIT]               = exl_q;
    sr_rd[IE_BIT]                = ie_q;

    cause_rd                     = '0;
    cause_rd[BD_BIT]             = bd_q;
    cause_rd[IP_LSB +: HWINT_W]  = ip_q;
    cause_rd[EXC_LSB +: EXC_W]   = exc_q;

    case (bus.A1)
      REG_SR:    dout = sr_rd;
      REG_CAUSE: dout = cause_rd;
      REG_EPC:   dout = epc_q;
      REG_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end

  assign bus.Req  = req;
  assign bus.EPC  = epc_q;
  assign bus.Dout = dout;

  // Bits that no register field stores, plus arbiter detail not needed here.
  logic unused_bits;
  assign unused_bits = ^{bus.Din[31:IM_LSB+HWINT_W], bus.Din[IM_LSB-1:2], bus.PC[1:0],
                         int_req, exc_req};

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: hand-computed expectations for reset,
// interrupt/exception entry, eret re-entry, read-only registers and EPC wrap.
module tb_cp0_int_ctrl;
  import cp0_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  cp0_int_ctrl_if #(.HWINT_W(6)) bus ();

  cp0_int_ctrl #(
    .PRID    (32'h1234_5678),
    .HWINT_W (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] idx, input string tag, input logic [31:0] exp);
    bus.A1 = idx;
    #1;
    check(tag, bus.Dout, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset       = 1'b0;
    bus.A1      = '0;
    bus.A2      = '0;
    bus.Din     = '0;
    bus.WE      = 1'b0;
    bus.PC      = '0;
    bus.BD      = 1'b0;
    bus.ExcCode = '0;
    bus.HWInt   = '0;
    bus.EXLClr  = 1'b0;

    // Reset state
    #2;
    check("rst_req", {31'd0, bus.Req}, 32'd0);
    rd(REG_SR, "rst_sr", 32'h0);
    rd(REG_EPC, "rst_epc_rd", 32'h0);
    rd(REG_PRID, "rst_prid", 32'h1234_5678);
    #10;
    reset = 1'b1;
    tick();

    // mtc0 SR = IM0 | IE, then timer IRQ
    bus.WE = 1'b1; bus.A2 = REG_SR; bus.Din = 32'h0000_0401;
    tick();
    bus.WE = 1'b0;
    rd(REG_SR, "sr_write", 32'h0000_0401);
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010; bus.BD = 1'b0;
    #1;
    check("irq_req", {31'd0, bus.Req}, 32'd1);
    tick();
    check("irq_req_exl", {31'd0, bus.Req}, 32'd0);
    check("irq_epc", bus.EPC, 32'h0000_3010);
    rd(REG_SR, "irq_sr", 32'h0000_0403);
    rd(REG_CAUSE, "irq_cause", 32'h0000_0400);

    // eret with IRQ still high: re-entry next cycle
    bus.EXLClr = 1'b1;
    #1;
    check("eret_req_same", {31'd0, bus.Req}, 32'd0);
    tick();
    bus.EXLClr = 1'b0;
    #1;
    check("reentry_req", {31'd0, bus.Req}, 32'd1);
    rd(REG_SR, "reentry_sr", 32'h0000_0401);
    tick();
    check("reentry_taken", {31'd0, bus.Req}, 32'd0);
    bus.HWInt = 6'b000000; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    #1;
    check("eret_noirq_req", {31'd0, bus.Req}, 32'd0);
    rd(REG_SR, "eret_noirq_sr", 32'h0000_0401);
    tick();
    check("eret_noirq_req2", {31'd0, bus.Req}, 32'd0);

    // Overflow in a delay slot
    bus.ExcCode = EXC_OV; bus.PC = 32'h0000_3020; bus.BD = 1'b1;
    #1;
    check("ov_req", {31'd0, bus.Req}, 32'd1);
    tick();
    bus.ExcCode = '0; bus.BD = 1'b0;
    check("ov_epc", bus.EPC, 32'h0000_301C);
    rd(REG_CAUSE, "ov_cause", 32'h8000_0030);
    rd(REG_SR, "ov_sr", 32'h0000_0403);
    check("ov_req_after", {31'd0, bus.Req}, 32'd0);

    // IRQ + RI together, with a same-cycle mtc0 EPC that must be dropped
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    bus.HWInt = 6'b000001; bus.ExcCode = EXC_RI; bus.PC = 32'h0000_4000;
    bus.WE = 1'b1; bus.A2 = REG_EPC; bus.Din = 32'h0000_5000;
    #1;
    check("both_req", {31'd0, bus.Req}, 32'd1);
    tick();
    bus.WE = 1'b0; bus.ExcCode = '0;
    check("both_epc", bus.EPC, 32'h0000_4000);
    rd(REG_CAUSE, "both_cause", 32'h0000_0400);

    // Cause and PRId are read-only; IP keeps tracking HWInt
    bus.HWInt = 6'b100010;
    bus.WE = 1'b1; bus.A2 = REG_CAUSE; bus.Din = 32'hFFFF_FFFF;
    tick();
    bus.A2 = REG_PRID;
    tick();
    bus.WE = 1'b0;
    rd(REG_CAUSE, "ro_cause", 32'h0000_8800);
    rd(REG_PRID, "ro_prid", 32'h1234_5678);
    rd(5'd3, "unmapped", 32'h0);
    check("ro_req", {31'd0, bus.Req}, 32'd0);

    // eret wins EXL over a simultaneous SR write
    bus.HWInt = '0; bus.EXLClr = 1'b1;
    bus.WE = 1'b1; bus.A2 = REG_SR; bus.Din = 32'h0000_0003;
    tick();
    bus.EXLClr = 1'b0; bus.WE = 1'b0;
    rd(REG_SR, "eret_vs_mtc0", 32'h0000_0001);

    // EPC wraps for PC=0 in a delay slot
    bus.ExcCode = EXC_ADEL; bus.PC = 32'h0; bus.BD = 1'b1;
    #1;
    check("wrap_req", {31'd0, bus.Req}, 32'd1);
    tick();
    bus.ExcCode = '0; bus.BD = 1'b0;
    check("wrap_epc", bus.EPC, 32'hFFFF_FFFC);
    rd(REG_CAUSE, "wrap_cause", 32'h8000_0010);

    // mtc0 EPC aligns the address, then async reset mid-cycle
    bus.WE = 1'b1; bus.A2 = REG_EPC; bus.Din = 32'h0000_3007;
    tick();
    bus.WE = 1'b0;
    check("mtc0_epc", bus.EPC, 32'h0000_3004);
    rd(REG_SR, "pre_rst_sr", 32'h0000_0003);
    #3;
    reset = 1'b0;
    #1;
    check("async_epc", bus.EPC, 32'h0);
    check("async_req", {31'd0, bus.Req}, 32'd0);
    rd(REG_EPC, "async_epc_rd", 32'h0);
    rd(REG_SR, "async_sr", 32'h0);
    rd(REG_CAUSE, "async_cause", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
